// File: rtl/ddr4_app_master_if.sv
// User request/response stream plus MIG native app signals for one DDR4 channel.
// The master modport is the initiator's view; slave is the peer (user logic + MIG).
interface ddr4_app_master_if #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 512
);
  localparam int MASK_W = DATA_W / 8;

  logic              req_valid;
  logic              req_ready;
  logic              req_wr;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [MASK_W-1:0] req_wmask;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              app_en;
  logic [2:0]        app_cmd;
  logic [ADDR_W-1:0] app_addr;
  logic              app_hi_pri;
  logic              app_rdy;
  logic              app_wdf_wren;
  logic [DATA_W-1:0] app_wdf_data;
  logic [MASK_W-1:0] app_wdf_mask;
  logic              app_wdf_end;
  logic              app_wdf_rdy;
  logic [DATA_W-1:0] app_rd_data;
  logic              app_rd_data_valid;

  modport master (
    input  req_valid, req_wr, req_addr, req_wdata, req_wmask, rsp_ready,
           app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid,
    output req_ready, rsp_valid, rsp_rdata, app_en, app_cmd, app_addr, app_hi_pri,
           app_wdf_wren, app_wdf_data, app_wdf_mask, app_wdf_end
  );

  modport slave (
    output req_valid, req_wr, req_addr, req_wdata, req_wmask, rsp_ready,
           app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid,
    input  req_ready, rsp_valid, rsp_rdata, app_en, app_cmd, app_addr, app_hi_pri,
           app_wdf_wren, app_wdf_data, app_wdf_mask, app_wdf_end
  );
endinterface

// File: rtl/ddr4_app_master.sv
// Single-beat request stream to DDR4 MIG app interface; read data returns through a
// credit-guarded show-ahead FIFO so app_rd_data (which cannot be stalled) is never lost.
module ddr4_app_master #(
  parameter int ADDR_W        = 28,
  parameter int DATA_W        = 512,
  parameter int RD_FIFO_DEPTH = 16
) (
  input  logic              ddr4_ui_clk,
  input  logic              ddr4_ui_rst_n,
  input  logic              init_calib_complete,
  ddr4_app_master_if.master bus,
  output logic              busy
);
  localparam int MASK_W = DATA_W / 8;
  localparam int PTR_W  = $clog2(RD_FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH  = CNT_W'(RD_FIFO_DEPTH);
  localparam logic [2:0]       CMD_WR = 3'b000;
  localparam logic [2:0]       CMD_RD = 3'b001;

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_WR, S_RD} state_e;

  typedef struct packed {
    logic [2:0]        cmd;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [MASK_W-1:0] mask;
  } app_req_t;

  state_e            state_q, state_d;
  app_req_t          req_q, req_d;
  logic              req_ready_q, req_ready_d;
  logic              app_en_q, app_en_d;
  logic              wren_q, wren_d;
  logic [CNT_W-1:0]  credit_q, credit_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  wptr_q, wptr_d;
  logic [PTR_W-1:0]  rptr_q, rptr_d;
  logic [DATA_W-1:0] mem_q [RD_FIFO_DEPTH];

  logic accept, cmd_fire, rd_fire, cmd_left, wdf_left, push, pop, rsp_valid;

  assign accept    = bus.req_valid & req_ready_q;
  assign cmd_fire  = app_en_q & bus.app_rdy;
  assign rd_fire   = cmd_fire & (state_q == S_RD);
  assign cmd_left  = app_en_q & ~bus.app_rdy;
  assign wdf_left  = wren_q & ~bus.app_wdf_rdy;
  assign push      = bus.app_rd_data_valid;
  assign rsp_valid = (count_q != '0);
  assign pop       = rsp_valid & bus.rsp_ready;

  // State register
  always_ff @(posedge ddr4_ui_clk or negedge ddr4_ui_rst_n) begin
    if (!ddr4_ui_rst_n) state_q <= S_INIT;
    else                state_q <= state_d;
  end

  // Next state: a command in flight always finishes before calibration loss is honoured
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_INIT: if (init_calib_complete) state_d = S_IDLE;
      S_IDLE: begin
        if (accept)                    state_d = bus.req_wr ? S_WR : S_RD;
        else if (!init_calib_complete) state_d = S_INIT;
      end
      S_WR: if (!cmd_left && !wdf_left) state_d = init_calib_complete ? S_IDLE : S_INIT;
      S_RD: if (cmd_fire)               state_d = init_calib_complete ? S_IDLE : S_INIT;
      default: state_d = S_INIT;
    endcase
  end

  // Registered outputs, credit and FIFO bookkeeping
  always_comb begin
    req_d    = req_q;
    app_en_d = cmd_left;
    wren_d   = wdf_left;
    if (accept) begin
      req_d.cmd  = bus.req_wr ? CMD_WR : CMD_RD;
      req_d.addr = bus.req_addr;
      req_d.data = bus.req_wdata;
      req_d.mask = bus.req_wmask;
      app_en_d   = 1'b1;
      wren_d     = bus.req_wr;
    end
    // Ready is only re-armed from IDLE, giving the 3-cycle minimum request spacing
    req_ready_d = (state_q == S_IDLE) && init_calib_complete && (credit_q != '0) && !accept;
    // A credit is consumed when the read is issued, returned when its data leaves the FIFO
    credit_d = credit_q - CNT_W'(rd_fire) + CNT_W'(pop);
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    wptr_d   = wptr_q + PTR_W'(push);
    rptr_d   = rptr_q + PTR_W'(pop);
  end

  always_ff @(posedge ddr4_ui_clk or negedge ddr4_ui_rst_n) begin
    if (!ddr4_ui_rst_n) begin
      req_q       <= '0;
      req_ready_q <= 1'b0;
      app_en_q    <= 1'b0;
      wren_q      <= 1'b0;
      credit_q    <= DEPTH;
      count_q     <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
    end else begin
      req_q       <= req_d;
      req_ready_q <= req_ready_d;
      app_en_q    <= app_en_d;
      wren_q      <= wren_d;
      credit_q    <= credit_d;
      count_q     <= count_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
    end
  end

  // Storage needs no reset: pointers and count define what is valid
  always_ff @(posedge ddr4_ui_clk) begin
    if (push) mem_q[wptr_q] <= bus.app_rd_data;
  end

  assign bus.req_ready    = req_ready_q;
  assign bus.rsp_valid    = rsp_valid;
  assign bus.rsp_rdata    = rsp_valid ? mem_q[rptr_q] : '0;
  assign bus.app_en       = app_en_q;
  assign bus.app_cmd      = req_q.cmd;
  assign bus.app_addr     = req_q.addr;
  assign bus.app_hi_pri   = 1'b0;
  assign bus.app_wdf_wren = wren_q;
  assign bus.app_wdf_end  = wren_q;
  assign bus.app_wdf_data = req_q.data;
  assign bus.app_wdf_mask = req_q.mask;
  assign busy = ((state_q == S_WR) || (state_q == S_RD)) || (credit_q != DEPTH);

  a_no_push_full: assert property (@(posedge ddr4_ui_clk) disable iff (!ddr4_ui_rst_n)
    !(push && (count_q == DEPTH)));
  a_credit_range: assert property (@(posedge ddr4_ui_clk) disable iff (!ddr4_ui_rst_n)
    credit_q <= DEPTH);
endmodule

// File: tb/tb_ddr4_app_master.sv
// Randomized bench: transaction-level memory model predicts app commands and read
// responses; a behavioural MIG model with random stalls and read latency drives the DUT.
module tb_ddr4_app_master;
  localparam int AW = 28;
  localparam int DW = 512;
  localparam int MW = DW / 8;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic calib = 1'b0;
  logic busy;

  ddr4_app_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  ddr4_app_master #(.ADDR_W(AW), .DATA_W(DW), .RD_FIFO_DEPTH(DEPTH)) dut (
    .ddr4_ui_clk        (clk),
    .ddr4_ui_rst_n      (rst_n),
    .init_calib_complete(calib),
    .bus                (bus),
    .busy               (busy)
  );

  always #5 clk = ~clk;

  typedef struct { logic [2:0] cmd; logic [AW-1:0] addr; } cmd_t;
  typedef struct { logic [DW-1:0] data; logic [MW-1:0] mask; } wd_t;
  typedef struct { int due; logic [DW-1:0] data; } rd_t;

  int total = 0;
  int bad = 0;
  int rdy_pct = 100, wdf_pct = 100, rsp_pct = 100;
  int app_hold = 0, wdf_hold = 0;
  int cyc = 0, last_due = 0;

  cmd_t exp_cmd[$];
  wd_t  exp_wd[$];
  logic [DW-1:0] exp_rsp[$];
  rd_t  rdq[$];
  logic [AW-1:0] mig_wa[$];
  wd_t  mig_wd[$];
  logic [DW-1:0] ref_mem [logic [AW-1:0]];
  logic [DW-1:0] mig_mem [logic [AW-1:0]];

  task automatic chk(input bit ok, input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] d, input logic [MW-1:0] m);
    logic [DW-1:0] r;
    for (int b = 0; b < MW; b++) r[b*8 +: 8] = m[b] ? old[b*8 +: 8] : d[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : '0;
  endfunction

  function automatic logic [DW-1:0] mig_rd(input logic [AW-1:0] a);
    return mig_mem.exists(a) ? mig_mem[a] : '0;
  endfunction

  // Present one request; on acceptance update the reference memory and queue expectations
  task automatic issue(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [MW-1:0] m, input int max_wait, output bit ok);
    int n;
    n = 0;
    ok = 1'b0;
    bus.req_wr = wr; bus.req_addr = a; bus.req_wdata = d; bus.req_wmask = m;
    bus.req_valid = 1'b1;
    forever begin
      if (bus.req_ready) begin
        ok = 1'b1;
        if (wr) begin
          exp_cmd.push_back('{3'b000, a});
          exp_wd.push_back('{d, m});
          ref_mem[a] = merge(ref_rd(a), d, m);
        end else begin
          exp_cmd.push_back('{3'b001, a});
          exp_rsp.push_back(ref_rd(a));
        end
        @(posedge clk); #2;
        break;
      end
      if (n >= max_wait) break;
      @(posedge clk); #2;
      n++;
    end
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_drain(input int max, input string name);
    int n;
    n = 0;
    while ((exp_rsp.size() != 0 || busy) && n < max) begin
      @(negedge clk); n++;
    end
    chk(n < max, name, n, max);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // MIG model: random ready stalls, in-order read return after random latency
  initial begin
    cmd_t e;
    wd_t  w;
    logic [2:0] p_cmd;
    logic [AW-1:0] p_addr;
    logic [DW-1:0] p_data;
    logic [MW-1:0] p_mask;
    bit en_stall, wd_stall;
    int due;
    en_stall = 0; wd_stall = 0;
    bus.app_rdy = 1'b0; bus.app_wdf_rdy = 1'b0;
    bus.app_rd_data_valid = 1'b0; bus.app_rd_data = '0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (app_hold > 0) begin bus.app_rdy = 1'b0; app_hold--; end
      else bus.app_rdy = ($urandom_range(99) < rdy_pct);
      if (wdf_hold > 0) begin bus.app_wdf_rdy = 1'b0; wdf_hold--; end
      else bus.app_wdf_rdy = ($urandom_range(99) < wdf_pct);
      if (rst_n && rdq.size() > 0 && rdq[0].due <= cyc) begin
        bus.app_rd_data_valid = 1'b1;
        bus.app_rd_data = rdq[0].data;
        void'(rdq.pop_front());
      end else begin
        bus.app_rd_data_valid = 1'b0;
        bus.app_rd_data = '0;
      end
      @(negedge clk);
      if (!rst_n) begin
        en_stall = 0; wd_stall = 0;
        continue;
      end
      if (en_stall)
        chk(bus.app_en && bus.app_cmd == p_cmd && bus.app_addr == p_addr, "app_stable",
            {bus.app_en, bus.app_cmd, bus.app_addr}, {1'b1, p_cmd, p_addr});
      if (wd_stall)
        chk(bus.app_wdf_wren && bus.app_wdf_data == p_data && bus.app_wdf_mask == p_mask,
            "wdf_stable", bus.app_wdf_data, p_data);
      if (bus.app_wdf_wren) chk(bus.app_wdf_end == 1'b1 && bus.app_hi_pri == 1'b0, "wdf_end",
                                {bus.app_wdf_end, bus.app_hi_pri}, 2'b10);
      if (bus.app_wdf_wren && bus.app_wdf_rdy) begin
        if (exp_wd.size() == 0) chk(1'b0, "wdf_unexpected", bus.app_wdf_data, '0);
        else begin
          w = exp_wd.pop_front();
          chk(bus.app_wdf_data == w.data && bus.app_wdf_mask == w.mask, "wdf_data",
              {bus.app_wdf_mask, bus.app_wdf_data[DW-MW-1:0]}, {w.mask, w.data[DW-MW-1:0]});
        end
        mig_wd.push_back('{bus.app_wdf_data, bus.app_wdf_mask});
      end
      if (bus.app_en && bus.app_rdy) begin
        if (exp_cmd.size() == 0) chk(1'b0, "cmd_unexpected", bus.app_addr, '0);
        else begin
          e = exp_cmd.pop_front();
          chk(bus.app_cmd == e.cmd && bus.app_addr == e.addr, "cmd_addr",
              {bus.app_cmd, bus.app_addr}, {e.cmd, e.addr});
        end
        if (bus.app_cmd == 3'b000) mig_wa.push_back(bus.app_addr);
        else begin
          due = cyc + $urandom_range(1, 5);
          if (due <= last_due) due = last_due + 1;
          last_due = due;
          rdq.push_back('{due, mig_rd(bus.app_addr)});
        end
      end
      while (mig_wa.size() > 0 && mig_wd.size() > 0) begin
        w = mig_wd.pop_front();
        mig_mem[mig_wa[0]] = merge(mig_rd(mig_wa[0]), w.data, w.mask);
        void'(mig_wa.pop_front());
      end
      en_stall = bus.app_en && !bus.app_rdy;
      wd_stall = bus.app_wdf_wren && !bus.app_wdf_rdy;
      p_cmd = bus.app_cmd; p_addr = bus.app_addr;
      p_data = bus.app_wdf_data; p_mask = bus.app_wdf_mask;
    end
  end

  // User-side response acceptance
  initial begin
    bus.rsp_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      bus.rsp_ready = ($urandom_range(99) < rsp_pct);
    end
  end

  // Response scoreboard monitor
  initial begin
    logic [DW-1:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
        if (exp_rsp.size() == 0) chk(1'b0, "rsp_unexpected", bus.rsp_rdata, '0);
        else begin
          e = exp_rsp.pop_front();
          chk(bus.rsp_rdata == e, "rsp_data", bus.rsp_rdata, e);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int acc;
    logic [DW-1:0] a5;
    logic [DW-1:0] d3;
    bus.req_valid = 1'b0; bus.req_wr = 1'b0; bus.req_addr = '0;
    bus.req_wdata = '0; bus.req_wmask = '0;
    #1 rst_n = 1'b0;
    idle(3);
    chk({bus.req_ready, bus.rsp_valid, bus.app_en, bus.app_wdf_wren, busy} == 5'b0,
        "reset_outputs", {bus.req_ready, bus.rsp_valid, bus.app_en, bus.app_wdf_wren, busy}, '0);
    chk({bus.app_cmd, bus.app_wdf_end, bus.app_hi_pri} == 5'b0, "reset_cmd",
        {bus.app_cmd, bus.app_wdf_end, bus.app_hi_pri}, '0);
    rst_n = 1'b1;

    // T1: no acceptance before calibration
    bus.req_wr = 1'b1; bus.req_addr = 28'h20; bus.req_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk(!bus.req_ready && !bus.app_en, "t1_blocked", {bus.req_ready, bus.app_en}, '0);
    end
    calib = 1'b1;
    issue(1'b1, 28'h20, rand_data(), '0, 3, ok);
    chk(ok, "t1_accept_after_calib", ok, 1);

    // T2: write with both sides ready
    wait_drain(100, "t2_pre_drain");
    for (int i = 0; i < DW / 8; i++) a5[i*8 +: 8] = 8'hA5;
    issue(1'b1, 28'h100, a5, '0, 10, ok);
    chk(ok, "t2_accept", ok, 1);
    @(negedge clk);
    chk(bus.app_en && bus.app_wdf_wren, "t2_both_high", {bus.app_en, bus.app_wdf_wren}, 2'b11);
    chk(bus.app_cmd == 3'b000 && bus.app_wdf_end, "t2_cmd_end", {bus.app_cmd, bus.app_wdf_end}, 4'b0001);
    @(negedge clk);
    chk(!bus.app_en && !bus.app_wdf_wren, "t2_one_cycle", {bus.app_en, bus.app_wdf_wren}, 2'b00);

    // T3: write data stalled 5 cycles
    idle(3);
    d3 = rand_data();
    wdf_hold = 1000;
    issue(1'b1, 28'h104, d3, 64'h00000000_0000FF00, 10, ok);
    chk(ok, "t3_accept", ok, 1);
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      chk(bus.app_wdf_wren, "t3_wren_held", bus.app_wdf_wren, 1);
      chk(bus.app_en == (i == 1), "t3_app_en", bus.app_en, (i == 1));
      chk(!bus.req_ready, "t3_req_ready_low", bus.req_ready, 0);
      if (i == 5) wdf_hold = 0;
    end
    @(negedge clk);
    chk(!bus.app_wdf_wren, "t3_wren_drop", bus.app_wdf_wren, 0);
    issue(1'b0, 28'h100, '0, '0, 20, ok);
    issue(1'b0, 28'h104, '0, '0, 20, ok);
    wait_drain(200, "t3_readback_drain");

    // T4: fill all credits with responses blocked
    rsp_pct = 0;
    for (int i = 0; i < DEPTH; i++) begin
      issue(1'b0, AW'($urandom_range(0, 15)) + 28'h200, '0, '0, 10, ok);
      chk(ok, "t4_read_accept", ok, 1);
    end
    issue(1'b0, 28'h200, '0, '0, 30, ok);
    chk(!ok, "t4_17th_blocked", ok, 0);
    rsp_pct = 100;
    wait_drain(300, "t4_drain");

    // T5: issue and pop coincide at credit=1
    rsp_pct = 0;
    for (int i = 0; i < DEPTH - 1; i++) issue(1'b0, 28'h104, '0, '0, 10, ok);
    idle(15);
    app_hold = 1000;
    issue(1'b0, 28'h100, '0, '0, 10, ok);
    chk(ok, "t5_accept", ok, 1);
    @(negedge clk);
    app_hold = 0; rsp_pct = 100;
    @(negedge clk);
    chk(bus.app_en && bus.app_rdy && bus.rsp_valid && bus.rsp_ready, "t5_same_cycle",
        {bus.app_en, bus.app_rdy, bus.rsp_valid, bus.rsp_ready}, 4'hF);
    rsp_pct = 0;
    idle(15);
    issue(1'b0, 28'h20, '0, '0, 10, ok);
    chk(ok, "t5_last_credit", ok, 1);
    issue(1'b0, 28'h20, '0, '0, 20, ok);
    chk(!ok, "t5_credit_exhausted", ok, 0);
    rsp_pct = 100;
    wait_drain(300, "t5_drain");

    // Random mixed traffic
    rdy_pct = 70; wdf_pct = 70; rsp_pct = 60;
    acc = 0;
    for (int i = 0; i < 150; i++) begin
      issue(1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)) + 28'h300, rand_data(),
            ($urandom_range(0, 2) == 0) ? '0 : {$urandom, $urandom}, 200, ok);
      if (ok) acc++;
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 4));
    end
    chk(acc == 150, "rand_all_accepted", acc, 150);
    wait_drain(2000, "rand_drain");

    // T6: reset while a read command is stalled
    rdy_pct = 100; wdf_pct = 100; rsp_pct = 0;
    issue(1'b0, 28'h300, '0, '0, 10, ok);
    idle(10);
    app_hold = 1000;
    issue(1'b0, 28'h301, '0, '0, 10, ok);
    @(negedge clk);
    chk(bus.app_en && !bus.app_rdy && bus.rsp_valid, "t6_precond",
        {bus.app_en, bus.app_rdy, bus.rsp_valid}, 3'b101);
    calib = 1'b0;
    rst_n = 1'b0;
    #1;
    chk({bus.app_en, bus.rsp_valid, busy, bus.req_ready} == 4'b0, "t6_async_clear",
        {bus.app_en, bus.rsp_valid, busy, bus.req_ready}, '0);
    exp_rsp.delete(); exp_cmd.delete(); exp_wd.delete();
    rdq.delete(); mig_wa.delete(); mig_wd.delete();
    app_hold = 0; last_due = 0;
    idle(3);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk({bus.req_ready, busy, bus.app_en} == 3'b0, "t6_back_in_init",
          {bus.req_ready, busy, bus.app_en}, '0);
    end
    calib = 1'b1;
    rsp_pct = 100;
    issue(1'b1, 28'h400, rand_data(), '0, 10, ok);
    chk(ok, "t6_post_write", ok, 1);
    issue(1'b0, 28'h400, '0, '0, 10, ok);
    chk(ok, "t6_post_read", ok, 1);
    issue(1'b0, 28'h300, '0, '0, 10, ok);
    wait_drain(300, "final_drain");
    chk(exp_cmd.size() == 0 && exp_wd.size() == 0, "leftover_cmds",
        exp_cmd.size() + exp_wd.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
